// File: rtl/pad_capture_pkg.sv
// Shared types and default constants for the pad input capture block.
package pad_capture_pkg;

    typedef enum logic {
        STABLE    = 1'b0,
        CANDIDATE = 1'b1
    } filt_state_e;

    localparam int DEF_FILTER_CYCLES = 4;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_TS_W          = 32;

endpackage

// File: rtl/pad_sync2.sv
// Two-flop synchronizer bringing the asynchronous pad level into the clk domain.
module pad_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pad_input_capture.sv
// Pad input capture: synchronize, glitch-filter, count edges and queue one event.
// Optional PAD_CAPTURE_TIMESTAMP_EN adds a free-running timestamp carried with each event.
module pad_input_capture
    import pad_capture_pkg::*;
#(
    parameter int FILTER_CYCLES = DEF_FILTER_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
`ifdef PAD_CAPTURE_TIMESTAMP_EN
    ,
    parameter int TS_W          = DEF_TS_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             paddi,
    input  logic             en,
    output logic             level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_level,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    input  logic             overflow_clr
`ifdef PAD_CAPTURE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  evt_ts
`endif
);

    localparam logic [7:0] RC_LAST = 8'(FILTER_CYCLES - 1);

    logic s;

    filt_state_e      state_q, state_d;
    logic [7:0]       rc_q, rc_d;
    logic             level_q, level_d;
    logic             toggle;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_level_q, evt_level_d;
    logic [CNT_W-1:0] evt_count_q, evt_count_d;
    logic             ovf_q, ovf_d;
    logic             ovf_set;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_cnt_q, ts_cnt_d;
    logic [TS_W-1:0]  evt_ts_q, evt_ts_d;
`endif

    pad_sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (paddi),
        .q   (s)
    );

    // Filter: a new level is accepted only after FILTER_CYCLES matching samples.
    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        toggle  = 1'b0;
        if (!en) begin
            state_d = STABLE;
            rc_d    = 8'd0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (s != level_q) begin
                        if (FILTER_CYCLES == 1) begin
                            toggle = 1'b1;
                        end else begin
                            state_d = CANDIDATE;
                            rc_d    = 8'd1;
                        end
                    end
                end
                CANDIDATE: begin
                    if (s == level_q) begin
                        state_d = STABLE;
                        rc_d    = 8'd0;
                    end else if (rc_q == RC_LAST) begin
                        toggle  = 1'b1;
                        state_d = STABLE;
                        rc_d    = 8'd0;
                    end else begin
                        rc_d = rc_q + 8'd1;
                    end
                end
                default: begin
                    state_d = STABLE;
                    rc_d    = 8'd0;
                end
            endcase
        end
        level_d = toggle ? ~level_q : level_q;
    end

    // Single-entry event holder; an event arriving while the holder is stalled is dropped.
    always_comb begin
        cnt_d       = cnt_q;
        evt_valid_d = evt_valid_q;
        evt_level_d = evt_level_q;
        evt_count_d = evt_count_q;
        ovf_set     = 1'b0;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
        ts_cnt_d    = ts_cnt_q + TS_W'(1);
        evt_ts_d    = evt_ts_q;
`endif
        if (toggle) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_level_d = level_d;
                evt_count_d = cnt_d;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
                evt_ts_d    = ts_cnt_q;
`endif
            end else begin
                ovf_set = 1'b1;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
        ovf_d = ovf_set ? 1'b1 : (overflow_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STABLE;
            rc_q        <= 8'd0;
            level_q     <= 1'b0;
            cnt_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_level_q <= 1'b0;
            evt_count_q <= '0;
            ovf_q       <= 1'b0;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
            ts_cnt_q    <= '0;
            evt_ts_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            evt_valid_q <= evt_valid_d;
            evt_level_q <= evt_level_d;
            evt_count_q <= evt_count_d;
            ovf_q       <= ovf_d;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
            ts_cnt_q    <= ts_cnt_d;
            evt_ts_q    <= evt_ts_d;
`endif
        end
    end

    assign level     = level_q;
    assign evt_valid = evt_valid_q;
    assign evt_level = evt_level_q;
    assign evt_count = evt_count_q;
    assign overflow  = ovf_q;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
    assign evt_ts    = evt_ts_q;
`endif

endmodule

// File: tb/tb_pad_input_capture.sv
// Bench for pad_input_capture: two instances (FILTER_CYCLES=4/CNT_W=16 and
// FILTER_CYCLES=1/CNT_W=2) share stimulus and are checked against a reference model.
module tb_pad_input_capture;

    logic clk = 1'b0;
    logic rst, paddi, en, evt_ready, overflow_clr;

    logic        a_level, a_evt_valid, a_evt_level, a_overflow;
    logic [15:0] a_evt_count;
    logic        b_level, b_evt_valid, b_evt_level, b_overflow;
    logic [1:0]  b_evt_count;
`ifdef PAD_CAPTURE_TIMESTAMP_EN
    logic [31:0] a_evt_ts, b_evt_ts;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pad_input_capture #(.FILTER_CYCLES(4), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .paddi(paddi), .en(en),
        .level(a_level), .evt_valid(a_evt_valid), .evt_ready(evt_ready),
        .evt_level(a_evt_level), .evt_count(a_evt_count),
        .overflow(a_overflow), .overflow_clr(overflow_clr)
`ifdef PAD_CAPTURE_TIMESTAMP_EN
        , .evt_ts(a_evt_ts)
`endif
    );

    pad_input_capture #(.FILTER_CYCLES(1), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .paddi(paddi), .en(en),
        .level(b_level), .evt_valid(b_evt_valid), .evt_ready(evt_ready),
        .evt_level(b_evt_level), .evt_count(b_evt_count),
        .overflow(b_overflow), .overflow_clr(overflow_clr)
`ifdef PAD_CAPTURE_TIMESTAMP_EN
        , .evt_ts(b_evt_ts)
`endif
    );

    // Reference model: s is paddi as sampled two edges earlier; a level flips once
    // s has disagreed with it for fc consecutive enabled samples.
    int   fc[2] = '{4, 1};
    int   cw[2] = '{16, 2};
    logic p1, p2;
    logic m_lvl[2], m_ev[2], m_evl[2], m_ovf[2];
    int   run[2], m_cnt[2], m_evc[2];

    task automatic model_reset();
        p1 = 1'b0;
        p2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_lvl[k] = 1'b0; m_ev[k] = 1'b0; m_evl[k] = 1'b0; m_ovf[k] = 1'b0;
            run[k] = 0; m_cnt[k] = 0; m_evc[k] = 0;
        end
    endtask

    task automatic model_step();
        logic s, tg, setf;
        if (rst) begin
            model_reset();
            return;
        end
        s  = p2;
        p2 = p1;
        p1 = paddi;
        for (int k = 0; k < 2; k++) begin
            tg   = 1'b0;
            setf = 1'b0;
            if (!en) run[k] = 0;
            else if (s != m_lvl[k]) begin
                run[k]++;
                if (run[k] >= fc[k]) begin
                    tg = 1'b1;
                    run[k] = 0;
                end
            end else run[k] = 0;
            if (tg) begin
                m_lvl[k] = ~m_lvl[k];
                m_cnt[k] = (m_cnt[k] + 1) % (1 << cw[k]);
                if (!m_ev[k] || evt_ready) begin
                    m_ev[k]  = 1'b1;
                    m_evl[k] = m_lvl[k];
                    m_evc[k] = m_cnt[k];
                end else setf = 1'b1;
            end else if (m_ev[k] && evt_ready) m_ev[k] = 1'b0;
            if (setf) m_ovf[k] = 1'b1;
            else if (overflow_clr) m_ovf[k] = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_level",     32'(a_level),     32'(m_lvl[0]));
        check("a_evt_valid", 32'(a_evt_valid), 32'(m_ev[0]));
        check("a_evt_level", 32'(a_evt_level), 32'(m_evl[0]));
        check("a_evt_count", 32'(a_evt_count), 32'(m_evc[0]));
        check("a_overflow",  32'(a_overflow),  32'(m_ovf[0]));
        check("b_level",     32'(b_level),     32'(m_lvl[1]));
        check("b_evt_valid", 32'(b_evt_valid), 32'(m_ev[1]));
        check("b_evt_level", 32'(b_evt_level), 32'(m_evl[1]));
        check("b_evt_count", 32'(b_evt_count), 32'(m_evc[1]));
        check("b_overflow",  32'(b_overflow),  32'(m_ovf[1]));
    endtask

    // Inputs change only at the falling edge; outputs are checked there too.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        int n, hold;
        logic lv;
        int exp35[5];
        exp35 = '{1, 2, 3, 0, 1};
        model_reset();
        rst = 1'b1; paddi = 1'b0; en = 1'b1; evt_ready = 1'b1; overflow_clr = 1'b0;
        @(negedge clk);
        tick(2);
        check("reset_level", 32'(a_level), 32'd0);
        check("reset_evt_valid", 32'(a_evt_valid), 32'd0);

        // Clean rising edge: level appears exactly 6 edges after paddi changes.
        rst = 1'b0; paddi = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!a_level && n < 20);
        check("rise_latency", 32'(n), 32'd6);
        check("rise_evt_valid", 32'(a_evt_valid), 32'd1);
        check("rise_evt_level", 32'(a_evt_level), 32'd1);
        check("rise_evt_count", 32'(a_evt_count), 32'd1);
        tick();
        check("rise_evt_drained", 32'(a_evt_valid), 32'd0);

        // Return low, then 1- and 3-cycle glitches that the 4-cycle filter must reject.
        paddi = 1'b0; tick(10);
        check("fall_count", 32'(a_evt_count), 32'd2);
        paddi = 1'b1; tick(1); paddi = 1'b0; tick(8);
        paddi = 1'b1; tick(3); paddi = 1'b0; tick(8);
        check("glitch_level", 32'(a_level), 32'd0);
        check("glitch_count", 32'(a_evt_count), 32'd2);

        // Back-pressure: first event held, later two dropped with overflow.
        rst = 1'b1; tick(); rst = 1'b0; evt_ready = 1'b0;
        for (int e = 0; e < 3; e++) begin paddi = ~paddi; tick(10); end
        check("bp_held_count", 32'(a_evt_count), 32'd1);
        check("bp_overflow", 32'(a_overflow), 32'd1);
        evt_ready = 1'b1; tick(); evt_ready = 1'b0;
        check("bp_drained", 32'(a_evt_valid), 32'd0);
        paddi = ~paddi; tick(10);
        check("bp_next_count", 32'(a_evt_count), 32'd4);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
        check("ovf_clear", 32'(a_overflow), 32'd0);

        // Narrow counter wraps on instance b (FILTER_CYCLES=1).
        rst = 1'b1; paddi = 1'b0; tick(); rst = 1'b0; evt_ready = 1'b1;
        for (int e = 0; e < 5; e++) begin
            paddi = ~paddi; tick(6);
            check("wrap_count", 32'(b_evt_count), 32'(exp35[e]));
        end

        // Enable low freezes the level; re-enable follows after FILTER_CYCLES edges.
        en = 1'b0; lv = a_level;
        for (int e = 0; e < 4; e++) begin paddi = ~paddi; tick(10); end
        check("en_frozen", 32'(a_level), 32'(lv));
        paddi = ~lv; tick(3);
        en = 1'b1;
        n = 0;
        do begin tick(); n++; end while (a_level == lv && n < 20);
        check("reen_latency", 32'(n), 32'd4);

        // Reset in the middle of a candidate run aborts it.
        paddi = ~a_level; lv = a_level; tick(4);
        check("cand_level", 32'(a_level), 32'(lv));
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_a_level", 32'(a_level), 32'd0);
        check("rst_a_valid", 32'(a_evt_valid), 32'd0);
        check("rst_a_count", 32'(a_evt_count), 32'd0);
        check("rst_b_count", 32'(b_evt_count), 32'd0);

        // Randomized run against the model.
        hold = 1;
        for (int c = 0; c < 3000; c++) begin
            hold--;
            if (hold <= 0) begin paddi = ~paddi; hold = $urandom_range(1, 9); end
            en           = ($urandom_range(0, 19) != 0);
            evt_ready    = ($urandom_range(0, 2) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            rst          = ($urandom_range(0, 499) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/pad_input_capture.md
PAD_INPUT_CAPTURE -- requirements
Module: pad_input_capture

Interface
REQ-001 SHALL have parameter FILTER_CYCLES, default 4: consecutive synchronized samples needed to accept a new level; legal range 1..255.
REQ-002 SHALL have parameter CNT_W, default 16: width of the edge counter.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port paddi, input, 1: raw pad input (PADDI side of the IO buffer), asynchronous to clk.
REQ-006 SHALL have port en, input, 1: filter/event enable.
REQ-007 SHALL have port level, output, 1: filtered pad level.
REQ-008 SHALL have port evt_valid, output, 1: event holding register occupied.
REQ-009 SHALL have port evt_ready, input, 1: consumer accepts event.
REQ-010 SHALL have port evt_level, output, 1: new level carried by the event.
REQ-011 SHALL have port evt_count, output, CNT_W: edge count including this event.
REQ-012 SHALL have port overflow, output, 1: sticky lost-event flag.
REQ-013 SHALL have port overflow_clr, input, 1: clears overflow.

Function
REQ-014 SHALL pass paddi through a 2-flop synchronizer; the filter sees only its output s.
REQ-015 SHALL run a filter FSM with states STABLE and CANDIDATE plus a run counter rc (8 bits).
REQ-016 STABLE: s==level -> stay; s!=level and FILTER_CYCLES==1 -> toggle level, stay; s!=level otherwise -> CANDIDATE, rc=1.
REQ-017 CANDIDATE: s==level -> STABLE, rc=0 (glitch rejected); s!=level and rc==FILTER_CYCLES-1 -> toggle level, STABLE, rc=0; else rc+1.
REQ-018 SHALL toggle level exactly 2+FILTER_CYCLES clk edges after the first edge sampling the new paddi value, given paddi held stable throughout.
REQ-019 SHALL, while en==0, force the FSM to STABLE with rc=0, freeze level, and generate no events; the synchronizer keeps running.
REQ-020 SHALL, on every level toggle, increment an internal edge counter (wraps at 2^CNT_W-1 -> 0) and form an event {new level, new count} in the same cycle that level changes.
REQ-021 SHALL load the event into the holding register if it is empty or is being drained in that cycle (evt_valid && evt_ready); evt_valid rises in the same cycle that level changes.
REQ-022 SHALL clear evt_valid on evt_valid && evt_ready with no new event that cycle.
REQ-023 SHALL, if a new event arrives while evt_valid && !evt_ready, keep the held event unchanged, drop the new event (counter still increments), and set overflow.
REQ-024 SHALL hold evt_level/evt_count stable while evt_valid && !evt_ready.
REQ-025 SHALL clear overflow on overflow_clr; a simultaneous set wins over clear.

Reset
REQ-026 SHALL on rst set synchronizer flops, level, evt_valid, evt_level, evt_count, edge counter, rc and overflow to 0 and the FSM to STABLE; rst mid-filtering aborts the candidate with no event.
REQ-027 SHALL ignore en, evt_ready and overflow_clr while rst is high.

Configuration
REQ-028 With PAD_CAPTURE_TIMESTAMP_EN defined, SHALL add parameter TS_W (default 32), output port evt_ts[TS_W-1:0], and a free-running counter cleared by rst and wrapping; evt_ts is loaded with the counter value of the cycle the level toggled and follows the REQ-021/023/024 rules.
REQ-029 Without PAD_CAPTURE_TIMESTAMP_EN, SHALL contain no timestamp counter and no evt_ts port; all other behaviour is identical.

Structure
REQ-030 SHALL place the filter state enum (STABLE, CANDIDATE) and the default FILTER_CYCLES/CNT_W/TS_W constants in package pad_capture_pkg.
REQ-031 SHALL implement the 2-flop synchronizer as sub-module pad_sync2 (ports clk, rst, d, q).

Verification
REQ-032 rst, then paddi 0->1 held, FILTER_CYCLES=4, evt_ready=1 -> level=1 and evt_valid pulse exactly 6 cycles later, evt_level=1, evt_count=1.
REQ-033 paddi 1-cycle and 3-cycle high glitches with FILTER_CYCLES=4 -> level stays 0, no event, evt_count unchanged.
REQ-034 evt_ready=0, three accepted edges -> held event evt_count=1 unchanged, overflow=1; then evt_ready=1 for one cycle -> evt_valid=0; next edge -> evt_count=4.
REQ-035 CNT_W=2, 5 accepted edges with evt_ready=1 -> evt_count sequence 1,2,3,0,1.
REQ-036 en=0 while paddi toggles -> no events, level frozen; en=1 with paddi differing -> level follows after FILTER_CYCLES cycles; rst asserted during CANDIDATE -> no event, all outputs 0.
REQ-037 With PAD_CAPTURE_TIMESTAMP_EN, edge accepted at cycle 100 after rst -> evt_ts=100, held unchanged under back-pressure.
